// File: rtl/eth_rx_parcer_scheduler_pkg.sv
// Shared definitions for the Rx frame scheduler: buffer geometry, decoder
// indices and the scheduler state encoding.
package eth_rx_parcer_scheduler_pkg;

  localparam int ETH_ADDR_W = 11;
  localparam int ETH_WORD_W = 16;

  localparam int DEC_ARP  = 0;
  localparam int DEC_IPV4 = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_TX_KICK,
    S_TX_WAIT,
    S_RELEASE,
    S_HOLD
  } sched_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_parcer_scheduler_port_mux.sv
// Selects one decoder's buffer address/data/strobe slice by index; all
// outputs are forced to zero when the enable is low.
module eth_dec_port_mux
  import eth_rx_parcer_scheduler_pkg::*;
#(
  parameter int NUM_DEC       = 2,
  parameter int DEC_IDX_WIDTH = 1,
  parameter int WORD_W        = ETH_WORD_W
) (
  input  logic [DEC_IDX_WIDTH-1:0]      sel,
  input  logic                          en,
  input  logic [NUM_DEC*ETH_ADDR_W-1:0] dec_rx_addr,
  input  logic [NUM_DEC*ETH_ADDR_W-1:0] dec_tx_addr,
  input  logic [NUM_DEC*WORD_W-1:0]     dec_tx_data,
  input  logic [NUM_DEC-1:0]            dec_tx_strobe,
  output logic [ETH_ADDR_W-1:0]         rx_addr,
  output logic [ETH_ADDR_W-1:0]         tx_addr,
  output logic [WORD_W-1:0]             tx_data,
  output logic                          tx_strobe
);

  always_comb begin
    rx_addr   = '0;
    tx_addr   = '0;
    tx_data   = '0;
    tx_strobe = 1'b0;
    for (int i = 0; i < NUM_DEC; i++) begin
      if (en && (sel == DEC_IDX_WIDTH'(i))) begin
        rx_addr   = dec_rx_addr[i*ETH_ADDR_W +: ETH_ADDR_W];
        tx_addr   = dec_tx_addr[i*ETH_ADDR_W +: ETH_ADDR_W];
        tx_data   = dec_tx_data[i*WORD_W +: WORD_W];
        tx_strobe = dec_tx_strobe[i];
      end
    end
  end

endmodule

// File: rtl/eth_rx_parcer_scheduler.sv
// Offers each received frame to the decoder chain in priority order, routes
// the accepting decoder onto the shared buffers, kicks Tx and releases Rx.
module eth_rx_parcer_scheduler
  import eth_rx_parcer_scheduler_pkg::*;
#(
  parameter int NUM_DEC        = 2,
  parameter int DEC_IDX_WIDTH  = 1,
  parameter int Eth_WORD_WIDTH = ETH_WORD_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              Rx_Frame_Ready,
  input  logic [ETH_ADDR_W-1:0]             Rx_Frame_Len,
  output logic                              Rx_Frame_Release,
  output logic [NUM_DEC-1:0]                Dec_Parcer_RQ,
  output logic [ETH_ADDR_W-1:0]             Dec_NUM_Data,
  input  logic [NUM_DEC-1:0]                Dec_In_Progress,
  input  logic [NUM_DEC-1:0]                Dec_TRUE_RQ,
  input  logic [NUM_DEC-1:0]                Dec_NOT_RQ,
  input  logic [NUM_DEC-1:0]                Dec_Tx_Start,
  input  logic [NUM_DEC*ETH_ADDR_W-1:0]     Dec_Rx_Addr,
  input  logic [NUM_DEC*ETH_ADDR_W-1:0]     Dec_Tx_Addr,
  input  logic [NUM_DEC*Eth_WORD_WIDTH-1:0] Dec_Tx_Data,
  input  logic [NUM_DEC-1:0]                Dec_Tx_Word_Strobe,
  output logic [ETH_ADDR_W-1:0]             Rx_Addr,
  output logic [ETH_ADDR_W-1:0]             Tx_Addr,
  output logic [Eth_WORD_WIDTH-1:0]         Tx_Data,
  output logic                              Tx_Word_Strobe,
  output logic                              Tx_Send,
  input  logic                              Tx_Busy,
  output logic [DEC_IDX_WIDTH-1:0]          Active_Dec,
  output logic [15:0]                       Frames_Dropped,
  output logic                              Timeout_Error
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0]         TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEC_IDX_WIDTH-1:0] LAST_DEC = DEC_IDX_WIDTH'(NUM_DEC - 1);

  sched_state_t             state, state_nxt;
  logic [DEC_IDX_WIDTH-1:0] active_nxt;
  logic [TMR_W-1:0]         tmr, tmr_nxt;
  logic                     busy_seen, busy_seen_nxt;
  logic                     drop, timeout, send;
  logic                     sel_true, sel_not, sel_start, tmr_done;
  logic                     unused_in_progress;

  // Busy flags are informational only; the result pulses drive sequencing.
  assign unused_in_progress = ^Dec_In_Progress;

  assign sel_true  = Dec_TRUE_RQ[Active_Dec];
  assign sel_not   = Dec_NOT_RQ[Active_Dec];
  assign sel_start = Dec_Tx_Start[Active_Dec];
  assign tmr_done  = (tmr == TMR_LAST);

  always_comb begin
    state_nxt     = state;
    active_nxt    = Active_Dec;
    busy_seen_nxt = busy_seen;
    drop          = 1'b0;
    timeout       = 1'b0;
    send          = 1'b0;
    case (state)
      S_IDLE: if (Rx_Frame_Ready) begin
        active_nxt = DEC_IDX_WIDTH'(DEC_ARP);
        state_nxt  = S_REQ;
      end
      // A result from the selected decoder always beats a same-cycle timeout.
      S_REQ: begin
        if (sel_true && sel_start) begin
          state_nxt = S_TX_KICK;
        end else if (sel_true) begin
          state_nxt = S_RELEASE;
        end else if (sel_not) begin
          if (Active_Dec != LAST_DEC) begin
            active_nxt = Active_Dec + 1'b1;
            state_nxt  = S_GAP;
          end else begin
            drop      = 1'b1;
            state_nxt = S_RELEASE;
          end
        end else if (tmr_done) begin
          timeout   = 1'b1;
          drop      = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_GAP: state_nxt = S_REQ;
      S_TX_KICK: if (!Tx_Busy) begin
        send          = 1'b1;
        busy_seen_nxt = 1'b0;
        state_nxt     = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (Tx_Busy) busy_seen_nxt = 1'b1;
        if (busy_seen && !Tx_Busy) begin
          state_nxt = S_RELEASE;
        end else if (tmr_done) begin
          timeout   = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: state_nxt = S_HOLD;
      S_HOLD: if (!Rx_Frame_Ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Timer only runs while staying in a timed state; any entry restarts at 0.
    if ((state == state_nxt) && ((state == S_REQ) || (state == S_TX_WAIT)))
      tmr_nxt = tmr + 1'b1;
    else
      tmr_nxt = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= S_IDLE;
      Active_Dec     <= '0;
      tmr            <= '0;
      busy_seen      <= 1'b0;
      Frames_Dropped <= '0;
      Dec_Parcer_RQ  <= '0;
      Dec_NUM_Data   <= '0;
      Tx_Send        <= 1'b0;
      Timeout_Error  <= 1'b0;
    end else begin
      state      <= state_nxt;
      Active_Dec <= active_nxt;
      tmr        <= tmr_nxt;
      busy_seen  <= busy_seen_nxt;
      if (drop) Frames_Dropped <= sat_inc16(Frames_Dropped);
      if ((state == S_IDLE) && Rx_Frame_Ready) Dec_NUM_Data <= Rx_Frame_Len;
      Dec_Parcer_RQ <= (state_nxt == S_REQ) ? (NUM_DEC'(1) << active_nxt) : '0;
      Tx_Send       <= send;
      Timeout_Error <= timeout;
    end
  end

  assign Rx_Frame_Release = (state == S_RELEASE);

  eth_dec_port_mux #(
    .NUM_DEC       (NUM_DEC),
    .DEC_IDX_WIDTH (DEC_IDX_WIDTH),
    .WORD_W        (Eth_WORD_WIDTH)
  ) u_port_mux (
    .sel           (Active_Dec),
    .en            (state == S_REQ),
    .dec_rx_addr   (Dec_Rx_Addr),
    .dec_tx_addr   (Dec_Tx_Addr),
    .dec_tx_data   (Dec_Tx_Data),
    .dec_tx_strobe (Dec_Tx_Word_Strobe),
    .rx_addr       (Rx_Addr),
    .tx_addr       (Tx_Addr),
    .tx_data       (Tx_Data),
    .tx_strobe     (Tx_Word_Strobe)
  );

endmodule

// File: tb/tb_eth_rx_parcer_scheduler.sv
// Directed bench for the Rx frame scheduler: ARP reply, IPv4 fallthrough,
// unknown frame, hung decoder, busy transmitter, result/timeout tie, reset.
module tb_eth_rx_parcer_scheduler;
  import eth_rx_parcer_scheduler_pkg::*;

  localparam int NUM_DEC = 2;
  localparam int IDX_W   = 1;
  localparam int WW      = 16;
  localparam int TO      = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ready;
  logic [10:0]             len;
  logic                    release_o;
  logic [NUM_DEC-1:0]      rq;
  logic [10:0]             num_data;
  logic [NUM_DEC-1:0]      in_prog, true_rq, not_rq, tx_start, dec_strb;
  logic [NUM_DEC*11-1:0]   dec_rx_addr, dec_tx_addr;
  logic [NUM_DEC*WW-1:0]   dec_tx_data;
  logic [10:0]             rx_addr, tx_addr;
  logic [WW-1:0]           tx_data;
  logic                    tx_strb, tx_send, tx_busy, tmo;
  logic [IDX_W-1:0]        active_dec;
  logic [15:0]             dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int send_cnt = 0, rel_cnt = 0, tmo_cnt = 0, rq1_cnt = 0, strb_cnt = 0;
  int s_send, s_rel, s_tmo, s_rq1, s_strb;

  always #5 clk = ~clk;

  eth_rx_parcer_scheduler #(
    .NUM_DEC(NUM_DEC), .DEC_IDX_WIDTH(IDX_W), .Eth_WORD_WIDTH(WW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(clk), .Reset(rst), .Rx_Frame_Ready(ready), .Rx_Frame_Len(len),
    .Rx_Frame_Release(release_o), .Dec_Parcer_RQ(rq), .Dec_NUM_Data(num_data),
    .Dec_In_Progress(in_prog), .Dec_TRUE_RQ(true_rq), .Dec_NOT_RQ(not_rq),
    .Dec_Tx_Start(tx_start), .Dec_Rx_Addr(dec_rx_addr), .Dec_Tx_Addr(dec_tx_addr),
    .Dec_Tx_Data(dec_tx_data), .Dec_Tx_Word_Strobe(dec_strb), .Rx_Addr(rx_addr),
    .Tx_Addr(tx_addr), .Tx_Data(tx_data), .Tx_Word_Strobe(tx_strb), .Tx_Send(tx_send),
    .Tx_Busy(tx_busy), .Active_Dec(active_dec), .Frames_Dropped(dropped),
    .Timeout_Error(tmo)
  );

  // Pulse/level counters sampled mid-cycle
  always @(negedge clk) begin
    if (tx_send)   send_cnt <= send_cnt + 1;
    if (release_o) rel_cnt  <= rel_cnt + 1;
    if (tmo)       tmo_cnt  <= tmo_cnt + 1;
    if (rq[1])     rq1_cnt  <= rq1_cnt + 1;
    if (tx_strb)   strb_cnt <= strb_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_send = send_cnt; s_rel = rel_cnt; s_tmo = tmo_cnt; s_rq1 = rq1_cnt; s_strb = strb_cnt;
  endtask

  task automatic wait_release(input string tag, input int max_cyc);
    int n = 0;
    while (!release_o && n < max_cyc) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(release_o), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ready = 1'b0; len = '0; in_prog = '0; true_rq = '0; not_rq = '0;
    tx_start = '0; dec_strb = '0; dec_rx_addr = '0; dec_tx_addr = '0; dec_tx_data = '0;
    tx_busy = 1'b0;
    step(3);
    check_eq("rst_rq", 32'(rq), 0);
    check_eq("rst_active", 32'(active_dec), 0);
    check_eq("rst_dropped", 32'(dropped), 0);
    check_eq("rst_release", 32'(release_o), 0);
    check_eq("rst_send", 32'(tx_send), 0);
    check_eq("rst_tmo", 32'(tmo), 0);
    check_eq("rst_num_data", 32'(num_data), 0);
    check_eq("rst_strb", 32'(tx_strb), 0);
    rst = 1'b0;
    step(1);
    check_eq("idle_rq", 32'(rq), 0);

    // ARP reply
    snap();
    len = 11'd21; ready = 1'b1;
    dec_rx_addr[10:0] = 11'h155; dec_rx_addr[21:11] = 11'h2AA;
    step(1);
    check_eq("arp_rq", 32'(rq), 1);
    check_eq("arp_num_data", 32'(num_data), 21);
    check_eq("arp_active", 32'(active_dec), 0);
    check_eq("arp_rx_addr", 32'(rx_addr), 32'h155);
    step(28);
    check_eq("arp_rq_held", 32'(rq), 1);
    true_rq = 2'b01; tx_start = 2'b01;
    step(1);
    true_rq = '0; tx_start = '0;
    check_eq("arp_rq_drop", 32'(rq), 0);
    check_eq("arp_rx_gated", 32'(rx_addr), 0);
    step(1);
    check_eq("arp_send", 32'(tx_send), 1);
    tx_busy = 1'b1;
    step(50);
    check_eq("arp_no_early_rel", 32'(release_o), 0);
    tx_busy = 1'b0;
    wait_release("arp_release", 5);
    step(3);
    check_eq("arp_send_cnt", 32'(send_cnt - s_send), 1);
    check_eq("arp_rel_cnt", 32'(rel_cnt - s_rel), 1);
    check_eq("arp_tmo_cnt", 32'(tmo_cnt - s_tmo), 0);
    check_eq("arp_dropped", 32'(dropped), 0);
    ready = 1'b0;
    step(2);

    // IPv4 fallthrough
    snap();
    len = 11'd40; ready = 1'b1;
    step(1);
    step(7);
    not_rq = 2'b01;
    step(1);
    not_rq = '0;
    check_eq("ip_gap_rq", 32'(rq), 0);
    check_eq("ip_gap_active", 32'(active_dec), 1);
    step(1);
    check_eq("ip_rq1", 32'(rq), 2);
    dec_tx_addr[10:0] = 11'h7FF; dec_tx_data[15:0] = 16'hFFFF; dec_strb = 2'b11;
    for (int a = 6; a <= 21; a++) begin
      dec_tx_addr[21:11] = 11'(a);
      dec_tx_data[31:16] = 16'hA500 | 16'(a);
      #1;
      check_eq("ip_tx_addr", 32'(tx_addr), 32'(a));
      check_eq("ip_tx_data", 32'(tx_data), 32'hA500 | 32'(a));
      step(1);
    end
    check_eq("ip_tx_strb", 32'(tx_strb), 1);
    not_rq = 2'b01;
    step(1);
    not_rq = '0;
    check_eq("ip_ignore_rq", 32'(rq), 2);
    check_eq("ip_ignore_active", 32'(active_dec), 1);
    true_rq = 2'b10; tx_start = 2'b10;
    step(1);
    true_rq = '0; tx_start = '0;
    check_eq("ip_strb_gated", 32'(tx_strb), 0);
    check_eq("ip_addr_gated", 32'(tx_addr), 0);
    step(1);
    check_eq("ip_send", 32'(tx_send), 1);
    tx_busy = 1'b1;
    step(5);
    tx_busy = 1'b0;
    wait_release("ip_release", 5);
    step(2);
    check_eq("ip_send_cnt", 32'(send_cnt - s_send), 1);
    check_eq("ip_dropped", 32'(dropped), 0);
    dec_strb = '0; ready = 1'b0;
    step(2);

    // Unknown frame
    snap();
    ready = 1'b1;
    step(1);
    not_rq = 2'b01;
    step(1);
    not_rq = '0;
    step(1);
    dec_strb = 2'b10;
    #1;
    check_eq("unk_strb_req", 32'(tx_strb), 1);
    not_rq = 2'b10;
    step(1);
    not_rq = '0;
    check_eq("unk_release", 32'(release_o), 1);
    check_eq("unk_dropped", 32'(dropped), 1);
    check_eq("unk_strb_gated", 32'(tx_strb), 0);
    step(2);
    check_eq("unk_send_cnt", 32'(send_cnt - s_send), 0);
    check_eq("unk_strb_cnt", 32'(strb_cnt - s_strb), 1);
    dec_strb = '0; ready = 1'b0;
    step(2);

    // Hung decoder, then stale frame held in HOLD
    snap();
    ready = 1'b1;
    step(1);
    step(63);
    check_eq("hung_no_tmo_yet", 32'(tmo), 0);
    check_eq("hung_no_rel_yet", 32'(release_o), 0);
    check_eq("hung_rq_held", 32'(rq), 1);
    step(1);
    check_eq("hung_tmo", 32'(tmo), 1);
    check_eq("hung_release", 32'(release_o), 1);
    check_eq("hung_dropped", 32'(dropped), 2);
    check_eq("hung_rq_drop", 32'(rq), 0);
    step(5);
    check_eq("hold_release", 32'(release_o), 0);
    check_eq("hold_rq", 32'(rq), 0);
    check_eq("hold_rel_cnt", 32'(rel_cnt - s_rel), 1);
    check_eq("hung_rq1_cnt", 32'(rq1_cnt - s_rq1), 0);
    check_eq("hung_tmo_cnt", 32'(tmo_cnt - s_tmo), 1);
    ready = 1'b0;
    step(2);

    // Result and timeout on the same cycle: handled, no reply, no drop
    snap();
    ready = 1'b1;
    step(1);
    step(63);
    true_rq = 2'b01;
    step(1);
    true_rq = '0;
    check_eq("tie_release", 32'(release_o), 1);
    check_eq("tie_tmo", 32'(tmo), 0);
    check_eq("tie_dropped", 32'(dropped), 2);
    step(2);
    check_eq("tie_send_cnt", 32'(send_cnt - s_send), 0);
    check_eq("tie_tmo_cnt", 32'(tmo_cnt - s_tmo), 0);
    ready = 1'b0;
    step(2);

    // Transmitter already busy at kick time
    snap();
    ready = 1'b1; tx_busy = 1'b1;
    step(1);
    true_rq = 2'b01; tx_start = 2'b01;
    step(1);
    true_rq = '0; tx_start = '0;
    step(20);
    check_eq("busy_send_held", 32'(tx_send), 0);
    check_eq("busy_send_cnt0", 32'(send_cnt - s_send), 0);
    tx_busy = 1'b0;
    step(1);
    check_eq("busy_send", 32'(tx_send), 1);
    tx_busy = 1'b1;
    step(3);
    tx_busy = 1'b0;
    wait_release("busy_release", 5);
    step(5);
    check_eq("busy_hold_rq", 32'(rq), 0);
    check_eq("busy_rel_cnt", 32'(rel_cnt - s_rel), 1);
    check_eq("busy_send_cnt", 32'(send_cnt - s_send), 1);
    ready = 1'b0;
    step(2);

    // Reset while decoder 1 is being requested
    snap();
    ready = 1'b1;
    step(1);
    not_rq = 2'b01;
    step(1);
    not_rq = '0;
    step(1);
    check_eq("rr_rq1", 32'(rq), 2);
    rst = 1'b1;
    step(1);
    check_eq("rr_rq", 32'(rq), 0);
    check_eq("rr_active", 32'(active_dec), 0);
    check_eq("rr_release", 32'(release_o), 0);
    check_eq("rr_dropped", 32'(dropped), 0);
    rst = 1'b0;
    step(1);
    check_eq("rr_restart_rq", 32'(rq), 1);
    check_eq("rr_restart_active", 32'(active_dec), 0);
    step(1);
    check_eq("rr_rel_cnt", 32'(rel_cnt - s_rel), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
